// File: rtl/cnt_phase_sequencer.sv
//======================================================================
// Module  : cnt_phase_sequencer
// Purpose : Runs a PHASES-deep {threshold, direction, repeat} program
//           on an external threshold up/down counter.
// Rev     : 1.0  initial release
//======================================================================
`default_nettype none

module cnt_phase_sequencer #(
    parameter int N      = 4,
    parameter int PHASES = 4,
    localparam int PW    = $clog2(PHASES)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_cfg_we,
    input  logic [PW-1:0] i_cfg_addr,
    input  logic [N-1:0]  i_cfg_th,
    input  logic          i_cfg_dir,
    input  logic [3:0]    i_cfg_reps,
    output logic          o_cfg_err,
    input  logic          i_start,
    input  logic          i_abort,
    output logic          o_busy,
    output logic          o_done,
    output logic [PW-1:0] o_phase_idx,
    output logic          o_cnt_n_reset,
    output logic          o_cnt_enable,
    output logic          o_cnt_dn_up,
    output logic [N-1:0]  o_cnt_th,
    input  logic          i_cnt_timeout
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_RUN   = 3'd2,
        S_NEXT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t        r_state;
    logic [N-1:0]  r_th   [PHASES];
    logic          r_dir  [PHASES];
    logic [3:0]    r_reps [PHASES];
    logic [3:0]    r_rep_cnt;
    logic [PW-1:0] r_phase_idx;
    logic          r_cfg_err;
    logic          r_busy;
    logic          r_done;
    logic          r_cnt_n_reset;
    logic          r_cnt_enable;
    logic          r_cnt_dn_up;
    logic [N-1:0]  r_cnt_th;

    logic [PW-1:0] w_next_idx;
    logic [3:0]    w_rep_inc;
    logic          w_last_phase;

    assign w_next_idx   = r_phase_idx + 1'b1;
    assign w_rep_inc    = r_rep_cnt + 4'd1;
    // Final entry reached either by depth or by an end-of-program marker
    assign w_last_phase = (r_phase_idx == PW'(PHASES - 1)) || (r_reps[w_next_idx] == 4'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_rep_cnt     <= '0;
            r_phase_idx   <= '0;
            r_cfg_err     <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_cnt_n_reset <= 1'b1;
            r_cnt_enable  <= 1'b0;
            r_cnt_dn_up   <= 1'b0;
            r_cnt_th      <= '0;
            for (int i = 0; i < PHASES; i++) begin
                r_th[i]   <= '0;
                r_dir[i]  <= 1'b0;
                r_reps[i] <= '0;
            end
        end else begin
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;

            if (i_cfg_we && !i_abort) begin
                if (r_state == S_IDLE) begin
                    r_th[i_cfg_addr]   <= i_cfg_th;
                    r_dir[i_cfg_addr]  <= i_cfg_dir;
                    r_reps[i_cfg_addr] <= i_cfg_reps;
                end else begin
                    r_cfg_err <= 1'b1;
                end
            end

            if (i_abort && (r_state != S_IDLE)) begin
                r_state       <= S_IDLE;
                r_busy        <= 1'b0;
                r_cnt_enable  <= 1'b0;
                r_cnt_n_reset <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_start && !i_abort) begin
                            if (r_reps[0] != 4'd0) begin
                                r_state       <= S_CLEAR;
                                r_busy        <= 1'b1;
                                r_phase_idx   <= '0;
                                r_rep_cnt     <= '0;
                                r_cnt_n_reset <= 1'b0;
                                r_cnt_enable  <= 1'b0;
                                r_cnt_th      <= r_th[0];
                                r_cnt_dn_up   <= r_dir[0];
                            end else begin
                                r_done <= 1'b1;
                            end
                        end
                    end
                    S_CLEAR: begin
                        r_state       <= S_RUN;
                        r_cnt_n_reset <= 1'b1;
                        r_cnt_enable  <= 1'b1;
                    end
                    S_RUN: begin
                        if (i_cnt_timeout) begin
                            if (w_rep_inc == r_reps[r_phase_idx]) begin
                                r_state      <= S_NEXT;
                                r_cnt_enable <= 1'b0;
                            end else begin
                                r_rep_cnt <= w_rep_inc;
                            end
                        end
                    end
                    S_NEXT: begin
                        if (w_last_phase) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state       <= S_CLEAR;
                            r_phase_idx   <= w_next_idx;
                            r_rep_cnt     <= '0;
                            r_cnt_n_reset <= 1'b0;
                            r_cnt_th      <= r_th[w_next_idx];
                            r_cnt_dn_up   <= r_dir[w_next_idx];
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state      <= S_IDLE;
                        r_busy       <= 1'b0;
                        r_cnt_enable <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_cfg_err     = r_cfg_err;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_phase_idx   = r_phase_idx;
    assign o_cnt_n_reset = r_cnt_n_reset;
    assign o_cnt_enable  = r_cnt_enable;
    assign o_cnt_dn_up   = r_cnt_dn_up;
    assign o_cnt_th      = r_cnt_th;

endmodule

`default_nettype wire
